// File: rtl/uart_cmd_pkg.sv
// Shared types and character constants for the UART command sequencer.
package uart_cmd_pkg;

    typedef enum logic [2:0] {IDLE, COLLECT, CHECK, ACK} seq_state_t;

    localparam logic [7:0] CHAR_CR          = 8'h0D;
    localparam logic [7:0] CHAR_LF          = 8'h0A;
    localparam logic [7:0] DEFAULT_ACK_CHAR = 8'h4B;
    localparam logic [7:0] DEFAULT_NAK_CHAR = 8'h3F;

    function automatic logic is_terminator(input logic [7:0] ch);
        return (ch == CHAR_CR) || (ch == CHAR_LF);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// RX byte intake and TX ACK/NAK handshake between the UART and the command sequencer.
interface uart_cmd_sequencer_if #(parameter int DATA_WIDTH = 8);

    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  tx_ready;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;

    modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data);
    modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data);

endinterface

// File: rtl/cmd_timeout_timer.sv
// Idle-cycle counter; expired is high while the count sits at its last value.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int            TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames UART RX bytes into a fixed-length command window, strobes the matcher and returns ACK/NAK.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    CHARACTER_COUNT = 10,
    parameter int                    TIMEOUT_CYCLES  = 1_000_000,
    parameter logic [DATA_WIDTH-1:0] ACK_CHAR        = DATA_WIDTH'(DEFAULT_ACK_CHAR),
    parameter logic [DATA_WIDTH-1:0] NAK_CHAR        = DATA_WIDTH'(DEFAULT_NAK_CHAR)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ena,
    uart_cmd_sequencer_if.slave                   uart,
    output logic [DATA_WIDTH*CHARACTER_COUNT-1:0] sr_data,
    output logic                                  check_strobe,
    output logic                                  busy,
    output logic                                  overrun,
    output logic [7:0]                            frame_err_cnt
);

    localparam int            SW       = DATA_WIDTH * CHARACTER_COUNT;
    localparam int            CW       = $clog2(CHARACTER_COUNT + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CHARACTER_COUNT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CHARACTER_COUNT + 1);

    seq_state_t            state, next_state;
    logic [CW-1:0]         char_cnt;
    logic [DATA_WIDTH-1:0] tx_char;
    logic                  rx_fire, rx_term, rx_char, frame_full;
    logic                  timer_clear, timer_tick, expired;

    assign rx_fire    = ena && uart.rx_valid;
    assign rx_term    = is_terminator(uart.rx_data[7:0]);
    assign rx_char    = rx_fire && !rx_term;
    assign frame_full = (char_cnt == CNT_FULL);

    // The timer only runs while collecting and no byte arrives; any byte restarts it.
    assign timer_clear = ena && ((state != COLLECT) || uart.rx_valid);
    assign timer_tick  = ena && (state == COLLECT) && !uart.rx_valid;

    cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rx_char) next_state = COLLECT;
            COLLECT: begin
                if (rx_fire && rx_term) begin
                    next_state = frame_full ? CHECK : ACK;
                end else if (!rx_fire && expired) begin
                    next_state = IDLE;
                end
            end
            CHECK:   next_state = ACK;
            ACK:     if (uart.tx_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        check_strobe  = ena && (state == CHECK);
        busy          = (state != IDLE);
        uart.tx_valid = (state == ACK);
        uart.tx_data  = tx_char;
    end

    // The reply byte is chosen when the terminator lands, so it is already stable in ACK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_data       <= '0;
            char_cnt      <= '0;
            tx_char       <= '0;
            overrun       <= 1'b0;
            frame_err_cnt <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (rx_char) begin
                        sr_data  <= {sr_data[SW-DATA_WIDTH-1:0], uart.rx_data};
                        char_cnt <= CW'(1);
                    end
                end
                COLLECT: begin
                    if (rx_char) begin
                        sr_data <= {sr_data[SW-DATA_WIDTH-1:0], uart.rx_data};
                        if (char_cnt != CNT_MAX) char_cnt <= char_cnt + 1'b1;
                    end else if (rx_fire) begin
                        if (frame_full) begin
                            tx_char <= ACK_CHAR;
                        end else begin
                            tx_char <= NAK_CHAR;
                            if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 1'b1;
                        end
                    end else if (expired) begin
                        sr_data  <= '0;
                        char_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (rx_fire) overrun <= 1'b1;
                end
                ACK: begin
                    if (rx_fire) overrun <= 1'b1;
                    if (uart.tx_ready) begin
                        sr_data  <= '0;
                        char_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: directed frames, timeouts, overrun, reset and enable.
module tb_uart_cmd_sequencer;

    localparam int DW = 8;
    localparam int CC = 10;
    localparam int TO = 16;
    localparam int SW = DW * CC;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          ena     = 1'b1;
    logic [SW-1:0] sr_data;
    logic          check_strobe;
    logic          busy;
    logic          overrun;
    logic [7:0]    frame_err_cnt;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] exp_frame_q[$];
    logic [7:0]    exp_tx_q[$];
    logic [7:0]    held_tx    = 8'h00;
    logic          held_valid = 1'b0;

    uart_cmd_sequencer_if #(.DATA_WIDTH(DW)) uart_bus ();

    uart_cmd_sequencer #(
        .DATA_WIDTH      (DW),
        .CHARACTER_COUNT (CC),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ena           (ena),
        .uart          (uart_bus),
        .sr_data       (sr_data),
        .check_strobe  (check_strobe),
        .busy          (busy),
        .overrun       (overrun),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [SW-1:0] actual, input logic [SW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        uart_bus.rx_valid = 1'b1;
        uart_bus.rx_data  = b;
        @(posedge clk);
        #1;
        uart_bus.rx_valid = 1'b0;
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, busy, 0);
    endtask

    // Monitor: every strobe and every TX handshake must match the next queued expectation.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (check_strobe) begin
                if (exp_frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected check_strobe: sr_data %h, none expected", sr_data);
                end else begin
                    checkOutput("sr_data at strobe", sr_data, exp_frame_q.pop_front());
                end
            end
            if (uart_bus.tx_valid && held_valid) checkOutput("tx_data stable", uart_bus.tx_data, held_tx);
            if (uart_bus.tx_valid && uart_bus.tx_ready) begin
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected tx byte: got %h, none expected", uart_bus.tx_data);
                end else begin
                    checkOutput("tx_data at handshake", uart_bus.tx_data, exp_tx_q.pop_front());
                end
            end
            held_valid = uart_bus.tx_valid && !uart_bus.tx_ready;
            held_tx    = uart_bus.tx_data;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [SW-1:0] frame;
        uart_bus.rx_valid = 1'b0;
        uart_bus.rx_data  = 8'h00;
        uart_bus.tx_ready = 1'b1;
        #2;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset tx_valid", uart_bus.tx_valid, 0);
        checkOutput("reset sr_data", sr_data, 0);
        checkOutput("reset frame_err_cnt", frame_err_cnt, 0);
        checkOutput("reset overrun", overrun, 0);
        #21 reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] test 1: good frame with CR");
        exp_frame_q.push_back("SW: 0x1234");
        exp_tx_q.push_back(8'h4B);
        sendStr("SW: 0x1234");
        applyStimulus(8'h0D);
        waitIdle("frame1 idle", 10);
        checkOutput("frame1 frame_err_cnt", frame_err_cnt, 0);
        checkOutput("frame1 sr_data cleared", sr_data, 0);

        $display("[TB] test 2: short and long frames");
        exp_tx_q.push_back(8'h3F);
        sendStr("BT: 0x");
        applyStimulus(8'h0D);
        waitIdle("short idle", 10);
        checkOutput("short frame_err_cnt", frame_err_cnt, 1);
        exp_tx_q.push_back(8'h3F);
        sendStr("BT: 0x123456");
        applyStimulus(8'h0D);
        waitIdle("long idle", 10);
        checkOutput("long frame_err_cnt", frame_err_cnt, 2);
        exp_tx_q.push_back(8'h3F);
        sendStr("BT: 0x123456789ABCDEFGHIJK");
        applyStimulus(8'h0A);
        waitIdle("very long idle", 10);
        checkOutput("very long frame_err_cnt", frame_err_cnt, 3);

        $display("[TB] test 3: timeout");
        sendStr("SW: 0x");
        idleCycles(TO - 1);
        checkOutput("busy before expiry", busy, 1);
        idleCycles(1);
        checkOutput("busy after expiry", busy, 0);
        checkOutput("sr_data after expiry", sr_data, 0);
        sendStr("SW: 0x");
        idleCycles(TO - 1);
        applyStimulus("1");
        checkOutput("byte wins at expiry busy", busy, 1);
        frame = "SW: 0x1";
        checkOutput("byte wins at expiry sr_data", sr_data, frame);
        idleCycles(TO);
        checkOutput("second timeout busy", busy, 0);
        checkOutput("timeout frame_err_cnt", frame_err_cnt, 3);

        $display("[TB] test 4: ACK stall with overrun");
        frame = "SW: 0xABCD";
        exp_frame_q.push_back(frame);
        exp_tx_q.push_back(8'h4B);
        uart_bus.tx_ready = 1'b0;
        sendStr("SW: 0xABCD");
        applyStimulus(8'h0D);
        idleCycles(1);
        for (int i = 0; i < 50; i++) begin
            checkOutput("stall tx_valid", uart_bus.tx_valid, 1);
            checkOutput("stall sr_data", sr_data, frame);
            if (i == 5 || i == 10 || i == 15) applyStimulus("x");
            else idleCycles(1);
        end
        checkOutput("overrun set", overrun, 1);
        uart_bus.tx_ready = 1'b1;
        waitIdle("stall idle", 10);
        checkOutput("stall sr_data cleared", sr_data, 0);
        checkOutput("overrun sticky", overrun, 1);

        $display("[TB] test 5: terminators in IDLE, reset during ACK");
        applyStimulus(8'h0D);
        checkOutput("CR idle busy", busy, 0);
        applyStimulus(8'h0A);
        checkOutput("LF idle busy", busy, 0);
        applyStimulus(8'h0D);
        checkOutput("CR2 idle busy", busy, 0);
        checkOutput("terminators sr_data", sr_data, 0);
        exp_frame_q.push_back("SW: 0x9999");
        uart_bus.tx_ready = 1'b0;
        sendStr("SW: 0x9999");
        applyStimulus(8'h0D);
        idleCycles(1);
        checkOutput("pre-reset tx_valid", uart_bus.tx_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async tx_valid", uart_bus.tx_valid, 0);
        checkOutput("async tx_data", uart_bus.tx_data, 0);
        checkOutput("async busy", busy, 0);
        checkOutput("async sr_data", sr_data, 0);
        checkOutput("async overrun", overrun, 0);
        checkOutput("async frame_err_cnt", frame_err_cnt, 0);
        checkOutput("async check_strobe", check_strobe, 0);
        uart_bus.tx_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] test 6: enable freeze");
        sendStr("SW: 0x");
        ena = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus("Z");
        frame = "SW: 0x";
        checkOutput("frozen busy", busy, 1);
        checkOutput("frozen sr_data", sr_data, frame);
        checkOutput("frozen overrun", overrun, 0);
        ena = 1'b1;
        exp_frame_q.push_back("SW: 0x5678");
        exp_tx_q.push_back(8'h4B);
        sendStr("5678");
        applyStimulus(8'h0D);
        waitIdle("resume idle", 10);
        checkOutput("resume frame_err_cnt", frame_err_cnt, 0);

        idleCycles(2);
        checkOutput("frames consumed", exp_frame_q.size(), 0);
        checkOutput("tx bytes consumed", exp_tx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
